// File: rtl/axi4_lite_arbiter.sv
// axi4_lite_arbiter: two-master (IFU read-only, LSU read/write) to one AXI4-lite slave arbiter.
//
// The arbiter is a pure pass-through switch. It holds no addresses or data, and it grants
// one master at a time. From S_IDLE the LSU wins over the IFU. A grant is held until the
// transaction completes, which is the R handshake for a read and the B handshake for a write.
// Entering or leaving a grant always goes through one S_IDLE cycle, in which every
// valid/ready output is 0.
//
// Ports
//   clk, rst        : single clock; synchronous active-high reset
//   lsu_prerequest  : early LSU request; wins arbitration even without ARVALID/AWVALID
//   ifu_*           : IFU read channel (AR, R)
//   lsu_*           : LSU full AXI4-lite channels (AR, R, AW, W, B)
//   AR..BRESP       : slave-side AXI4-lite channels (no prefix)
//   gnt_ifu/gnt_lsu : current-grant indicators
module axi4_lite_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    // Must be at least 1
    parameter int unsigned PRE_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lsu_prerequest,
    // IFU read master
    input  logic [ADDR_W-1:0] ifu_ARADDR,
    input  logic              ifu_ARVALID,
    output logic              ifu_ARREADY,
    output logic [DATA_W-1:0] ifu_RDATA,
    output logic [1:0]        ifu_RRESP,
    output logic              ifu_RVALID,
    input  logic              ifu_RREADY,
    // LSU read/write master
    input  logic [ADDR_W-1:0] lsu_ARADDR,
    input  logic              lsu_ARVALID,
    output logic              lsu_ARREADY,
    output logic [DATA_W-1:0] lsu_RDATA,
    output logic [1:0]        lsu_RRESP,
    output logic              lsu_RVALID,
    input  logic              lsu_RREADY,
    input  logic [ADDR_W-1:0] lsu_AWADDR,
    input  logic              lsu_AWVALID,
    output logic              lsu_AWREADY,
    input  logic [DATA_W-1:0] lsu_WDATA,
    input  logic [3:0]        lsu_WSTRB,
    input  logic              lsu_WVALID,
    output logic              lsu_WREADY,
    output logic              lsu_BVALID,
    output logic [1:0]        lsu_BRESP,
    input  logic              lsu_BREADY,
    // Slave
    output logic [ADDR_W-1:0] ARADDR,
    output logic              ARVALID,
    input  logic              ARREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY,
    output logic [ADDR_W-1:0] AWADDR,
    output logic              AWVALID,
    input  logic              AWREADY,
    output logic [DATA_W-1:0] WDATA,
    output logic [3:0]        WSTRB,
    output logic              WVALID,
    input  logic              WREADY,
    input  logic              BVALID,
    input  logic [1:0]        BRESP,
    output logic              BREADY,
    // Grant indicators
    output logic              gnt_ifu,
    output logic              gnt_lsu
);

    typedef enum logic [1:0] {S_IDLE, S_IFU, S_LSU} state_e;

    localparam int unsigned        CNT_W   = $clog2(PRE_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(PRE_TIMEOUT);

    state_e           state_q, state_d;
    logic             started_q, started_d;
    // Kind of the LSU transaction in flight once started: 1 = write, 0 = read
    logic             is_wr_q, is_wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // An LSU read may issue until a write has started. A write may issue only when no read
    // is requested and no read has started. So AR and AW together always serve the read first.
    logic lsu_rd_ok, lsu_wr_ok;
    assign lsu_rd_ok = started_q ? ~is_wr_q : 1'b1;
    assign lsu_wr_ok = started_q ? is_wr_q  : ~lsu_ARVALID;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            started_q <= 1'b0;
            is_wr_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= started_d;
            is_wr_q   <= is_wr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next state. Handshakes are observed on the slave side, after grant gating.
    logic ar_hs, aw_hs, w_hs, addr_hs, rd_done, wr_done;
    logic [CNT_W-1:0] cnt_inc;

    always_comb begin
        ar_hs   = ARVALID & ARREADY;
        aw_hs   = AWVALID & AWREADY;
        w_hs    = WVALID & WREADY;
        addr_hs = ar_hs | aw_hs | w_hs;
        // A response counts only for a transaction this grant actually issued
        rd_done = RVALID & RREADY & (started_q | ar_hs);
        wr_done = BVALID & BREADY & (started_q | aw_hs | w_hs);
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

        state_d   = state_q;
        started_d = started_q;
        is_wr_d   = is_wr_q;
        cnt_d     = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                started_d = 1'b0;
                is_wr_d   = 1'b0;
                cnt_d     = '0;
                if (lsu_prerequest | lsu_ARVALID | lsu_AWVALID) begin
                    state_d = S_LSU;
                end else if (ifu_ARVALID) begin
                    state_d = S_IFU;
                end
            end
            S_IFU: begin
                if (addr_hs) started_d = 1'b1;
                if (rd_done) begin
                    state_d   = S_IDLE;
                    started_d = 1'b0;
                end
            end
            S_LSU: begin
                if (addr_hs && !started_q) begin
                    started_d = 1'b1;
                    is_wr_d   = aw_hs | w_hs;
                end
                if (rd_done | wr_done) begin
                    state_d   = S_IDLE;
                    started_d = 1'b0;
                end else if (!lsu_ARVALID && !lsu_AWVALID && !started_q) begin
                    // Prerequest-only grant: release once it has idled PRE_TIMEOUT cycles
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs: pure steering on the registered grant
    always_comb begin
        gnt_ifu     = 1'b0;
        gnt_lsu     = 1'b0;
        ifu_ARREADY = 1'b0;
        ifu_RDATA   = '0;
        ifu_RRESP   = '0;
        ifu_RVALID  = 1'b0;
        lsu_ARREADY = 1'b0;
        lsu_RDATA   = '0;
        lsu_RRESP   = '0;
        lsu_RVALID  = 1'b0;
        lsu_AWREADY = 1'b0;
        lsu_WREADY  = 1'b0;
        lsu_BVALID  = 1'b0;
        lsu_BRESP   = '0;
        ARADDR      = '0;
        ARVALID     = 1'b0;
        RREADY      = 1'b0;
        AWADDR      = '0;
        AWVALID     = 1'b0;
        WDATA       = '0;
        WSTRB       = '0;
        WVALID      = 1'b0;
        BREADY      = 1'b0;

        unique case (state_q)
            S_IFU: begin
                gnt_ifu     = 1'b1;
                ARADDR      = ifu_ARADDR;
                ARVALID     = ifu_ARVALID;
                RREADY      = ifu_RREADY;
                ifu_ARREADY = ARREADY;
                ifu_RDATA   = RDATA;
                ifu_RRESP   = RRESP;
                ifu_RVALID  = RVALID;
            end
            S_LSU: begin
                gnt_lsu     = 1'b1;
                ARADDR      = lsu_ARADDR;
                ARVALID     = lsu_ARVALID & lsu_rd_ok;
                RREADY      = lsu_RREADY & lsu_rd_ok;
                lsu_ARREADY = ARREADY & lsu_rd_ok;
                lsu_RDATA   = RDATA;
                lsu_RRESP   = RRESP;
                lsu_RVALID  = RVALID & lsu_rd_ok;
                AWADDR      = lsu_AWADDR;
                AWVALID     = lsu_AWVALID & lsu_wr_ok;
                WDATA       = lsu_WDATA;
                WSTRB       = lsu_WSTRB;
                WVALID      = lsu_WVALID & lsu_wr_ok;
                BREADY      = lsu_BREADY & lsu_wr_ok;
                lsu_AWREADY = AWREADY & lsu_wr_ok;
                lsu_WREADY  = WREADY & lsu_wr_ok;
                lsu_BVALID  = BVALID & lsu_wr_ok;
                lsu_BRESP   = BRESP;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
module tb_axi4_lite_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned PT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          lsu_prerequest;
    logic [AW-1:0] ifu_ARADDR;
    logic          ifu_ARVALID, ifu_ARREADY, ifu_RVALID, ifu_RREADY;
    logic [DW-1:0] ifu_RDATA;
    logic [1:0]    ifu_RRESP;
    logic [AW-1:0] lsu_ARADDR, lsu_AWADDR;
    logic          lsu_ARVALID, lsu_ARREADY, lsu_RVALID, lsu_RREADY;
    logic [DW-1:0] lsu_RDATA, lsu_WDATA;
    logic [1:0]    lsu_RRESP, lsu_BRESP;
    logic          lsu_AWVALID, lsu_AWREADY, lsu_WVALID, lsu_WREADY, lsu_BVALID, lsu_BREADY;
    logic [3:0]    lsu_WSTRB;
    logic [AW-1:0] ARADDR, AWADDR;
    logic          ARVALID, ARREADY, RVALID, RREADY, AWVALID, AWREADY;
    logic [DW-1:0] RDATA, WDATA;
    logic [1:0]    RRESP, BRESP;
    logic [3:0]    WSTRB;
    logic          WVALID, WREADY, BVALID, BREADY;
    logic          gnt_ifu, gnt_lsu;

    axi4_lite_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRE_TIMEOUT(PT)) dut (
        .clk(clk), .rst(rst), .lsu_prerequest(lsu_prerequest),
        .ifu_ARADDR(ifu_ARADDR), .ifu_ARVALID(ifu_ARVALID), .ifu_ARREADY(ifu_ARREADY),
        .ifu_RDATA(ifu_RDATA), .ifu_RRESP(ifu_RRESP), .ifu_RVALID(ifu_RVALID),
        .ifu_RREADY(ifu_RREADY),
        .lsu_ARADDR(lsu_ARADDR), .lsu_ARVALID(lsu_ARVALID), .lsu_ARREADY(lsu_ARREADY),
        .lsu_RDATA(lsu_RDATA), .lsu_RRESP(lsu_RRESP), .lsu_RVALID(lsu_RVALID),
        .lsu_RREADY(lsu_RREADY), .lsu_AWADDR(lsu_AWADDR), .lsu_AWVALID(lsu_AWVALID),
        .lsu_AWREADY(lsu_AWREADY), .lsu_WDATA(lsu_WDATA), .lsu_WSTRB(lsu_WSTRB),
        .lsu_WVALID(lsu_WVALID), .lsu_WREADY(lsu_WREADY), .lsu_BVALID(lsu_BVALID),
        .lsu_BRESP(lsu_BRESP), .lsu_BREADY(lsu_BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY), .RDATA(RDATA),
        .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY), .AWADDR(AWADDR),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .WVALID(WVALID), .WREADY(WREADY), .BVALID(BVALID), .BRESP(BRESP),
        .BREADY(BREADY), .gnt_ifu(gnt_ifu), .gnt_lsu(gnt_lsu)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pop the expected response queued when the slave side was driven
    task automatic chk_sb(input string tag, input logic [31:0] obs);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s: observed=%0h expected=<scoreboard empty>", tag, obs);
        end else begin
            chk(tag, obs, exp_q.pop_front());
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench timeout");
    end

    int n;

    initial begin
        rst = 1'b1; lsu_prerequest = 1'b0;
        ifu_ARADDR = '0; ifu_ARVALID = 1'b0; ifu_RREADY = 1'b0;
        lsu_ARADDR = '0; lsu_ARVALID = 1'b0; lsu_RREADY = 1'b0;
        lsu_AWADDR = '0; lsu_AWVALID = 1'b0; lsu_WDATA = '0; lsu_WSTRB = '0;
        lsu_WVALID = 1'b0; lsu_BREADY = 1'b0;
        ARREADY = 1'b0; RDATA = '0; RRESP = '0; RVALID = 1'b0; AWREADY = 1'b0;
        WREADY = 1'b0; BVALID = 1'b0; BRESP = '0;
        step(); step();
        chk("rst_gnt_ifu", gnt_ifu, 0);
        chk("rst_gnt_lsu", gnt_lsu, 0);
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_awvalid", AWVALID, 0);
        chk("rst_wvalid", WVALID, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_bready", BREADY, 0);
        rst = 1'b0;

        // IFU-only read
        ifu_ARADDR = 32'h8000_0000; ifu_ARVALID = 1'b1; ifu_RREADY = 1'b1; ARREADY = 1'b1;
        #1;
        chk("idle_ifu_arready", ifu_ARREADY, 0);
        chk("idle_arvalid", ARVALID, 0);
        step();
        chk("t1_gnt_ifu", gnt_ifu, 1);
        chk("t1_araddr", ARADDR, 32'h8000_0000);
        chk("t1_arvalid", ARVALID, 1);
        chk("t1_ifu_arready", ifu_ARREADY, 1);
        step();
        ifu_ARVALID = 1'b0; ARREADY = 1'b0;
        RVALID = 1'b1; RDATA = 32'h1234_5678; RRESP = 2'b00; exp_q.push_back(32'h1234_5678);
        #1;
        chk("t1_ifu_rvalid", ifu_RVALID, 1);
        chk("t1_rready", RREADY, 1);
        chk("t1_ifu_rresp", ifu_RRESP, 0);
        chk_sb("t1_ifu_rdata", ifu_RDATA);
        step();
        RVALID = 1'b0; RDATA = '0;
        #1;
        chk("t1_idle_ifu", gnt_ifu, 0);
        chk("t1_idle_lsu", gnt_lsu, 0);

        // Simultaneous IFU and LSU reads: LSU first
        ifu_ARADDR = 32'h8000_0040; ifu_ARVALID = 1'b1;
        lsu_ARADDR = 32'h0000_1000; lsu_ARVALID = 1'b1; lsu_RREADY = 1'b1; ARREADY = 1'b1;
        step();
        chk("t2_gnt_lsu", gnt_lsu, 1);
        chk("t2_gnt_ifu", gnt_ifu, 0);
        chk("t2_araddr", ARADDR, 32'h0000_1000);
        chk("t2_lsu_arready", lsu_ARREADY, 1);
        chk("t2_ifu_arready", ifu_ARREADY, 0);
        step();
        lsu_ARVALID = 1'b0; ARREADY = 1'b0;
        RVALID = 1'b1; RDATA = 32'hCAFE_0001; exp_q.push_back(32'hCAFE_0001);
        #1;
        chk("t2_lsu_rvalid", lsu_RVALID, 1);
        chk("t2_ifu_rvalid", ifu_RVALID, 0);
        chk("t2_ifu_arready_r", ifu_ARREADY, 0);
        chk_sb("t2_lsu_rdata", lsu_RDATA);
        step();
        RVALID = 1'b0;
        #1;
        chk("t2_idle_lsu", gnt_lsu, 0);
        chk("t2_idle_ifu", gnt_ifu, 0);
        step();
        chk("t2_ifu_granted", gnt_ifu, 1);
        chk("t2_ifu_araddr", ARADDR, 32'h8000_0040);
        ARREADY = 1'b1;
        step();
        ifu_ARVALID = 1'b0; ARREADY = 1'b0;
        RVALID = 1'b1; RDATA = 32'h0BAD_F00D; exp_q.push_back(32'h0BAD_F00D);
        #1;
        chk_sb("t2_ifu_rdata", ifu_RDATA);
        step();
        RVALID = 1'b0;
        #1;
        chk("t2_done", gnt_ifu, 0);

        // LSU write with slow AWREADY and BVALID
        lsu_AWADDR = 32'h8000_0100; lsu_AWVALID = 1'b1; lsu_WDATA = 32'hDEAD_BEEF;
        lsu_WSTRB = 4'hF; lsu_WVALID = 1'b1; lsu_BREADY = 1'b1;
        step();
        chk("t3_gnt_lsu", gnt_lsu, 1);
        chk("t3_awaddr", AWADDR, 32'h8000_0100);
        chk("t3_wdata", WDATA, 32'hDEAD_BEEF);
        chk("t3_wstrb", WSTRB, 4'hF);
        chk("t3_awvalid", AWVALID, 1);
        chk("t3_wvalid", WVALID, 1);
        chk("t3_lsu_awready", lsu_AWREADY, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_hold_aw", gnt_lsu, 1);
        end
        AWREADY = 1'b1; WREADY = 1'b1;
        #1;
        chk("t3_lsu_awready_fwd", lsu_AWREADY, 1);
        chk("t3_lsu_wready_fwd", lsu_WREADY, 1);
        step();
        lsu_AWVALID = 1'b0; lsu_WVALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
        #1;
        chk("t3_hold_b1", gnt_lsu, 1);
        chk("t3_no_bvalid", lsu_BVALID, 0);
        step();
        chk("t3_hold_b2", gnt_lsu, 1);
        BVALID = 1'b1; BRESP = 2'b00; exp_q.push_back(32'h0);
        #1;
        chk("t3_lsu_bvalid", lsu_BVALID, 1);
        chk("t3_bready", BREADY, 1);
        chk_sb("t3_lsu_bresp", lsu_BRESP);
        step();
        BVALID = 1'b0;
        #1;
        chk("t3_done", gnt_lsu, 0);

        // LSU AR and AW together: read served first, write after re-arbitration
        lsu_ARADDR = 32'h0000_2000; lsu_ARVALID = 1'b1;
        lsu_AWADDR = 32'h0000_3000; lsu_AWVALID = 1'b1; lsu_WDATA = 32'h55; lsu_WVALID = 1'b1;
        ARREADY = 1'b1; AWREADY = 1'b1; WREADY = 1'b1;
        step();
        chk("t4_gnt_lsu", gnt_lsu, 1);
        chk("t4_lsu_arready", lsu_ARREADY, 1);
        chk("t4_lsu_awready", lsu_AWREADY, 0);
        chk("t4_lsu_wready", lsu_WREADY, 0);
        chk("t4_awvalid", AWVALID, 0);
        chk("t4_wvalid", WVALID, 0);
        step();
        lsu_ARVALID = 1'b0; ARREADY = 1'b0;
        RVALID = 1'b1; RDATA = 32'h0000_2222; exp_q.push_back(32'h0000_2222);
        #1;
        chk("t4_awvalid_blocked", AWVALID, 0);
        chk("t4_awready_blocked", lsu_AWREADY, 0);
        chk_sb("t4_lsu_rdata", lsu_RDATA);
        step();
        RVALID = 1'b0;
        #1;
        chk("t4_idle", gnt_lsu, 0);
        step();
        chk("t4_wr_gnt", gnt_lsu, 1);
        chk("t4_wr_awvalid", AWVALID, 1);
        chk("t4_wr_awaddr", AWADDR, 32'h0000_3000);
        chk("t4_wr_awready", lsu_AWREADY, 1);
        chk("t4_wr_wready", lsu_WREADY, 1);
        step();
        lsu_AWVALID = 1'b0; lsu_WVALID = 1'b0; AWREADY = 1'b0; WREADY = 1'b0;
        BVALID = 1'b1; BRESP = 2'b10; exp_q.push_back(32'h2);
        #1;
        chk("t4_wr_bvalid", lsu_BVALID, 1);
        chk_sb("t4_wr_bresp", lsu_BRESP);
        step();
        BVALID = 1'b0; BRESP = 2'b00;
        #1;
        chk("t4_wr_done", gnt_lsu, 0);

        // Prerequest pulse with no LSU valid: timeout, then waiting IFU
        ifu_ARADDR = 32'h8000_0080; ifu_ARVALID = 1'b1; lsu_prerequest = 1'b1;
        step();
        lsu_prerequest = 1'b0;
        #1;
        n = 0;
        while (gnt_lsu === 1'b1 && n < 20) begin
            n++;
            step();
        end
        chk("t5_prereq_cycles", n, PT);
        chk("t5_idle_ifu", gnt_ifu, 0);
        chk("t5_idle_lsu", gnt_lsu, 0);
        step();
        chk("t5_ifu_next", gnt_ifu, 1);

        // Prerequest during an IFU read does not pre-empt it
        ARREADY = 1'b1; lsu_prerequest = 1'b1;
        #1;
        chk("t6_keep_ifu0", gnt_ifu, 1);
        step();
        ifu_ARVALID = 1'b0; ARREADY = 1'b0;
        #1;
        chk("t6_keep_ifu1", gnt_ifu, 1);
        step();
        chk("t6_keep_ifu2", gnt_ifu, 1);
        chk("t6_no_lsu", gnt_lsu, 0);
        RVALID = 1'b1; RDATA = 32'h0000_7777; exp_q.push_back(32'h0000_7777);
        ifu_ARADDR = 32'h8000_00C0; ifu_ARVALID = 1'b1;
        #1;
        chk_sb("t6_ifu_rdata", ifu_RDATA);
        step();
        RVALID = 1'b0;
        #1;
        chk("t6_idle_ifu", gnt_ifu, 0);
        chk("t6_idle_lsu", gnt_lsu, 0);
        step();
        chk("t6_lsu_wins", gnt_lsu, 1);
        chk("t6_ifu_waits", gnt_ifu, 0);
        lsu_prerequest = 1'b0;
        #1;
        n = 0;
        while (gnt_lsu === 1'b1 && n < 20) begin
            n++;
            step();
        end
        chk("t6_prereq_cycles", n, PT);
        step();
        chk("t6_ifu_after", gnt_ifu, 1);

        // Reset while slave RVALID is pending
        ARREADY = 1'b1; ifu_RREADY = 1'b0;
        step();
        ifu_ARVALID = 1'b0; ARREADY = 1'b0; RVALID = 1'b1; RDATA = 32'h0000_0099;
        #1;
        chk("t7_pending_rvalid", ifu_RVALID, 1);
        rst = 1'b1;
        step();
        chk("t7_rst_gnt_ifu", gnt_ifu, 0);
        chk("t7_rst_gnt_lsu", gnt_lsu, 0);
        chk("t7_rst_ifu_rvalid", ifu_RVALID, 0);
        chk("t7_rst_lsu_rvalid", lsu_RVALID, 0);
        chk("t7_rst_ifu_rdata", ifu_RDATA, 0);
        chk("t7_rst_lsu_rresp", lsu_RRESP, 0);
        chk("t7_rst_arvalid", ARVALID, 0);
        chk("t7_rst_rready", RREADY, 0);
        rst = 1'b0;
        step();
        chk("t7_post_ifu_rvalid", ifu_RVALID, 0);
        chk("t7_post_lsu_rvalid", lsu_RVALID, 0);
        chk("t7_post_gnt_ifu", gnt_ifu, 0);
        ifu_RREADY = 1'b1;
        step();
        chk("t7_post2_ifu_rvalid", ifu_RVALID, 0);
        RVALID = 1'b0;

        chk("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
